seg7_scan_driver: RTL and testbench

Multiplexed seven-segment display driver that consumes the divided clock produced by the clock-divider stage and scans a hex value across a common-anode display on the FPGA board. The divided clock is used only as a synchronous scan-rate reference: its rising edges are detected in the `clk` domain and each one advances the displayed digit. Display data is latched once per full scan frame, so a value that changes mid-frame does not produce mixed digits.

---
 rtl/seg7_pkg.sv | 23 ++
 rtl/hex_to_seg7.sv | 14 +
 rtl/seg7_scan_driver.sv | 176 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg
// Shared constants for the seven-segment scan driver.
//   HEX_SEG_TABLE : 16-entry hex-to-segment map, active-low, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK     : all segments off
//   ANODE_OFF     : all anodes off (wide enough for the largest digit count)
// Optional feature in the top level: SEG7_LZ_BLANK_EN (leading-zero blanking).
package seg7_pkg;

    typedef logic [3:0] nibble_t;
    typedef logic [6:0] seg_t;

    localparam int   MAX_DIGITS = 8;
    localparam seg_t SEG_BLANK  = 7'h7F;
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    localparam seg_t HEX_SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
        7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
        7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A B
        7'h46, 7'h21, 7'h06, 7'h0E    // C D E F
    };

endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7
// Purely combinational hex digit to seven-segment decoder.
//   hex   : 4-bit digit in
//   seg_n : active-low segments out, {g,f,e,d,c,b,a}
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg_n
);

    assign seg_n = HEX_SEG_TABLE[hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Multiplexed common-anode seven-segment scanner. The divided scan clock is
// sampled in the clk domain; each rising edge advances one digit. The displayed
// value is latched once per frame (when the scan wraps to digit 0).
// Ports:
//   clk        : system clock (only clock)
//   rst        : asynchronous active-low reset
//   scan_clk   : divided clock, used as data only
//   value      : N_DIGITS hex digits, digit 0 in value[3:0] (rightmost)
//   dp_mask    : decimal point request per digit, 1 = lit
//   anode_n    : active-low digit enables, one-hot-low while scanning
//   seg_n      : active-low segments {g,f,e,d,c,b,a}
//   dp_n       : active-low decimal point
//   digit_idx  : index of the currently driven digit
// Build option: define SEG7_LZ_BLANK_EN to blank leading zeros.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  scan_clk,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic [N_DIGITS-1:0]   dp_mask,
    output logic [N_DIGITS-1:0]   anode_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [2:0]            digit_idx
);

    // ------------------------------------------------------------------
    // Scan-rate edge detect. scan_q resets high so a divider output that
    // also resets high does not look like a rising edge after reset.
    // ------------------------------------------------------------------
    logic scan_q_reg;
    logic tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) scan_q_reg <= 1'b1;
        else      scan_q_reg <= scan_clk;
    end

    assign tick = scan_clk & ~scan_q_reg;

    // ------------------------------------------------------------------
    // Digit counter. started_reg makes the first tick after reset behave
    // as a wrap, so scanning restarts on digit 0 with a freshly latched
    // frame rather than on digit 1 with the reset (all-zero) frame.
    // ------------------------------------------------------------------
    logic [2:0] idx_reg;
    logic [2:0] idx_next;
    logic       started_reg;
    logic       wrap;

    assign wrap = tick & (~started_reg | (idx_reg == 3'(N_DIGITS - 1)));

    always_comb begin
        idx_next = idx_reg;
        if (wrap)      idx_next = 3'd0;
        else if (tick) idx_next = idx_reg + 3'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_reg     <= 3'd0;
            started_reg <= 1'b0;
        end else if (tick) begin
            idx_reg     <= idx_next;
            started_reg <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Frame latch: loads only on the wrap tick.
    // ------------------------------------------------------------------
    logic [4*N_DIGITS-1:0] frame_val_reg;
    logic [N_DIGITS-1:0]   frame_dp_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_val_reg <= '0;
            frame_dp_reg  <= '0;
        end else if (wrap) begin
            frame_val_reg <= value;
            frame_dp_reg  <= dp_mask;
        end
    end

    // ------------------------------------------------------------------
    // Per-digit views of the latched frame, plus leading-zero flags.
    // lead_zero[i] is set when digit i and every digit above it are zero.
    // ------------------------------------------------------------------
    logic [3:0]          frame_digit [N_DIGITS];
    logic [N_DIGITS-1:0] lead_zero;

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign frame_digit[gi] = frame_val_reg[4*gi +: 4];
            if (gi == N_DIGITS - 1) begin : g_top
                assign lead_zero[gi] = (frame_val_reg[4*gi +: 4] == 4'h0);
            end else begin : g_lower
                assign lead_zero[gi] = lead_zero[gi+1] &
                                       (frame_val_reg[4*gi +: 4] == 4'h0);
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Select the digit shown next. At a wrap the frame register has not
    // loaded yet, so digit 0 comes straight from the inputs being latched.
    // ------------------------------------------------------------------
    logic [3:0]          sel_hex;
    logic                sel_dp;
    logic                sel_lead_zero;
    logic [N_DIGITS-1:0] anode_next;

    always_comb begin
        sel_hex       = 4'h0;
        sel_dp        = 1'b0;
        sel_lead_zero = 1'b0;
        anode_next    = ANODE_OFF[N_DIGITS-1:0];
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx_next == 3'(i)) begin
                sel_hex       = frame_digit[i];
                sel_dp        = frame_dp_reg[i];
                sel_lead_zero = lead_zero[i];
                anode_next[i] = 1'b0;
            end
        end
        if (wrap) begin
            sel_hex       = value[3:0];
            sel_dp        = dp_mask[0];
            sel_lead_zero = 1'b0;
        end
    end

    logic [6:0] dec_seg;
    logic [6:0] seg_next;
    logic       blank;

    hex_to_seg7 u_hex_to_seg7 (
        .hex   (sel_hex),
        .seg_n (dec_seg)
    );

`ifdef SEG7_LZ_BLANK_EN
    // Digit 0 is never blanked so an all-zero value still shows "0".
    assign blank = sel_lead_zero & (idx_next != 3'd0);
`else
    assign blank = 1'b0;
    logic unused_lz;
    assign unused_lz = sel_lead_zero;
`endif

    assign seg_next = blank ? SEG_BLANK : dec_seg;

    // ------------------------------------------------------------------
    // Output registers: dark from reset until the first tick.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            anode_n   <= ANODE_OFF[N_DIGITS-1:0];
            seg_n     <= SEG_BLANK;
            dp_n      <= 1'b1;
            digit_idx <= 3'd0;
        end else if (tick) begin
            anode_n   <= anode_next;
            seg_n     <= seg_next;
            dp_n      <= ~sel_dp;
            digit_idx <= idx_next;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

    localparam int N = 4;

    typedef struct packed {
        logic [3:0] anode;
        logic [6:0] seg;
        logic       dp;
        logic [2:0] idx;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           scan_clk = 1'b0;
    logic [4*N-1:0] value = '0;
    logic [N-1:0]   dp_mask = '0;
    logic [N-1:0]   anode_n;
    logic [6:0]     seg_n;
    logic           dp_n;
    logic [2:0]     digit_idx;

    int checks = 0;
    int passes = 0;

    exp_t sb_q[$];
    exp_t last_exp;
    exp_t dark;

    // reference model state
    logic           m_started;
    int             m_idx;
    logic [4*N-1:0] m_frame_val;
    logic [N-1:0]   m_frame_dp;

    always #5 clk = ~clk;

    seg7_scan_driver #(.N_DIGITS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .scan_clk  (scan_clk),
        .value     (value),
        .dp_mask   (dp_mask),
        .anode_n   (anode_n),
        .seg_n     (seg_n),
        .dp_n      (dp_n),
        .digit_idx (digit_idx)
    );

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_out(input string tag, input exp_t e);
        chk({tag, ".anode_n"},   32'(anode_n),   32'(e.anode));
        chk({tag, ".seg_n"},     32'(seg_n),     32'(e.seg));
        chk({tag, ".dp_n"},      32'(dp_n),      32'(e.dp));
        chk({tag, ".digit_idx"}, 32'(digit_idx), 32'(e.idx));
    endtask

    task automatic model_reset();
        m_started   = 1'b0;
        m_idx       = 0;
        m_frame_val = '0;
        m_frame_dp  = '0;
        last_exp    = dark;
    endtask

    // Advance the model for one tick and push the expected outputs.
    task automatic model_tick();
        exp_t       e;
        logic [3:0] d;
        logic       blank;
        int         nxt;
        if (!m_started || m_idx == N - 1) begin
            m_frame_val = value;
            m_frame_dp  = dp_mask;
            nxt = 0;
        end else begin
            nxt = m_idx + 1;
        end
        m_started = 1'b1;
        m_idx     = nxt;
        d = m_frame_val[4*nxt +: 4];
        blank = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
        blank = (nxt != 0) && ((m_frame_val >> (4 * nxt)) == '0);
`endif
        e.anode      = '1;
        e.anode[nxt] = 1'b0;
        e.seg        = blank ? 7'h7F : seg_of(d);
        e.dp         = ~m_frame_dp[nxt];
        e.idx        = 3'(nxt);
        sb_q.push_back(e);
    endtask

    // One scan_clk period at the fastest divider rate (toggle every clk).
    task automatic do_tick(input string tag);
        exp_t e;
        @(posedge clk); #1;
        scan_clk = 1'b1;
        model_tick();
        chk_out({tag, ".pre_edge"}, last_exp);
        @(posedge clk); #1;
        if (sb_q.size() == 0) begin
            checks++;
            $error("FAIL %s.scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb_q.pop_front();
            chk_out(tag, e);
            last_exp = e;
        end
        scan_clk = 1'b0;
    endtask

    task automatic hold_check(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            chk_out(tag, last_exp);
        end
    endtask

    initial begin
        dark.anode = '1;
        dark.seg   = 7'h7F;
        dark.dp    = 1'b1;
        dark.idx   = 3'd0;
        model_reset();

        // reset held: display dark
        repeat (3) @(posedge clk);
        #1;
        chk_out("reset", dark);
        $display("step reset_hold anode_n=%b seg_n=%h", anode_n, seg_n);
        @(negedge clk);
        rst = 1'b1;

        // frame with 1234, then wrap
        value   = 16'h1234;
        dp_mask = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            do_tick("v1234");
            $display("tick v1234 anode_n=%b seg_n=%h dp_n=%b idx=%0d", anode_n, seg_n, dp_n, digit_idx);
        end

        // now on digit 0; tick to digit 1, then change value mid-frame
        do_tick("to_d1");
        value   = 16'hABCD;
        dp_mask = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            do_tick("midframe");
            $display("tick midframe anode_n=%b seg_n=%h dp_n=%b idx=%0d", anode_n, seg_n, dp_n, digit_idx);
        end

        // scan_clk held constant: outputs hold
        hold_check("hold", 6);
        $display("step hold anode_n=%b seg_n=%h", anode_n, seg_n);

        // advance to digit 2 then pulse reset asynchronously
        do_tick("to_d1b");
        do_tick("to_d2");
        chk("d2_active", 32'(digit_idx), 32'd2);
        @(negedge clk); #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk_out("async_rst", dark);
        $display("step async_rst anode_n=%b seg_n=%h", anode_n, seg_n);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst     = 1'b1;
        value   = 16'h9E07;
        dp_mask = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            do_tick("after_rst");
            $display("tick after_rst anode_n=%b seg_n=%h dp_n=%b idx=%0d", anode_n, seg_n, dp_n, digit_idx);
        end

        // leading zeros (blanked only with SEG7_LZ_BLANK_EN)
        value   = 16'h0005;
        dp_mask = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            do_tick("v0005");
            $display("tick v0005 anode_n=%b seg_n=%h idx=%0d", anode_n, seg_n, digit_idx);
        end
        value = 16'h0000;
        dp_mask = 4'b1000;
        for (int i = 0; i < 4; i++) begin
            do_tick("v0000");
            $display("tick v0000 anode_n=%b seg_n=%h idx=%0d", anode_n, seg_n, digit_idx);
        end
        value = 16'h0F00;
        for (int i = 0; i < 4; i++) begin
            do_tick("v0F00");
            $display("tick v0F00 anode_n=%b seg_n=%h idx=%0d", anode_n, seg_n, digit_idx);
        end

        // random frames, values change at arbitrary digits
        for (int i = 0; i < 16; i++) begin
            if (i % 3 == 0) begin
                value   = 16'($urandom);
                dp_mask = 4'($urandom);
            end
            do_tick("rand");
            $display("tick rand anode_n=%b seg_n=%h dp_n=%b idx=%0d", anode_n, seg_n, dp_n, digit_idx);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
